rf_wr_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between NREQ writeback requesters, e.g. ALU, load unit and CSR/debug.
- Uses round-robin arbitration with a per-requester valid/ready handshake.
- Registers the winning request and drives the register-file write port (wr/waddr/wdata) one cycle after the grant.
- Sits between the execute/memory writeback paths and the register file.

---
 rtl/rf_wr_arbiter.sv | 94 +++++++++
 tb/tb_rf_wr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters.
// Optional x0 write filter enabled by defining RF_ARB_X0_FILTER_EN.
module rf_wr_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wr_stall,
  output logic                 wr,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic            x0_hit;
  logic            wr_d;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            wr_q;
  logic [AW-1:0]   waddr_q;
  logic [DW-1:0]   wdata_q;
  int              scan_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    x0_hit   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    scan_idx = 0;
    if (!wr_stall && !reset) begin
`ifdef RF_ARB_X0_FILTER_EN
      // x0 writes are swallowed ahead of the rotation, lowest index first
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_any && req_valid[i] && (req_addr[i*AW +: AW] == '0)) begin
          gnt_any = 1'b1;
          x0_hit  = 1'b1;
          gnt_idx = PW'(i);
        end
      end
`endif
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = int'(ptr_q) + k;
        if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
        if (!gnt_any && req_valid[scan_idx]) begin
          gnt_any  = 1'b1;
          gnt_idx  = PW'(scan_idx);
          sel_addr = req_addr[scan_idx*AW +: AW];
          sel_data = req_data[scan_idx*DW +: DW];
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign wr_d  = gnt_any && !x0_hit;
  assign ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      wr_q <= wr_d;
      if (wr_d) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
        ptr_q   <= ptr_d;
      end
    end
  end

  assign req_ready = gnt;
  assign wr        = wr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = (|req_valid) | wr_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed and randomized bench for rf_wr_arbiter against a cycle-level reference model.
module tb_rf_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_stall;
  logic            wr;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            busy;

  rf_wr_arbiter #(.DW(DW), .AW(AW), .NREQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
    .wr(wr), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int            m_ptr;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_stall = 1'b0;
    req_valid = '1; req_addr = '0; req_data = '0;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    m_ptr = 0; m_wr = 1'b0; m_addr = '0; m_data = '0;
    reset = 1'b0; req_valid = '0;
  endtask

  // One cycle: drive, check combinational grant, clock, check registered port.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d, input logic st, output logic [N-1:0] rdy);
    int g;
    bit filt;
    logic [N-1:0] exp_rdy;
    req_valid = v; req_addr = a; req_data = d; wr_stall = st;
    g = -1; filt = 0;
    if (!st) begin
`ifdef RF_ARB_X0_FILTER_EN
      for (int i = 0; i < N; i++)
        if (g < 0 && v[i] && a[i*AW +: AW] == '0) begin g = i; filt = 1; end
`endif
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'((|v) | m_wr));
    rdy = req_ready;
    @(posedge clk); #1;
    if (g >= 0 && !filt) begin
      m_wr = 1'b1; m_addr = a[g*AW +: AW]; m_data = d[g*DW +: DW];
      m_ptr = (g + 1) % N;
    end else begin
      m_wr = 1'b0;
    end
    chk("wr", 64'(wr), 64'(m_wr));
    chk("waddr", 64'(waddr), 64'(m_addr));
    chk("wdata", 64'(wdata), 64'(m_data));
  endtask

  logic [N-1:0]    r;
  logic [N-1:0]    pv;
  logic [N*AW-1:0] pa;
  logic [N*DW-1:0] pd;

  initial begin
    reset = 1'b1; wr_stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;
    do_reset();

    // single write, latency one
    step(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, r);
    chk("t1_ready", 64'(r), 64'b001);
    chk("t1_wr", 64'(wr), 64'd1);
    chk("t1_waddr", 64'(waddr), 64'd5);
    chk("t1_wdata", 64'(wdata), 64'hDEADBEEF);
    step(3'b000, '0, '0, 1'b0, r);
    chk("t1_wr_off", 64'(wr), 64'd0);

    // full rotation from reset
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0, r);
      chk("rot_order", 64'(r), 64'(1 << (k % 3)));
      chk("rot_wr", 64'(wr), 64'd1);
    end

    // wrap: reach ptr=2, then 2 then 0
    do_reset();
    step(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h9, 32'h0}, 1'b0, r);
    step(3'b101, {5'd12, 5'd0, 5'd10}, {32'h12, 32'h0, 32'h10}, 1'b0, r);
    chk("wrap_g2", 64'(r), 64'b100);
    step(3'b001, {5'd12, 5'd0, 5'd10}, {32'h12, 32'h0, 32'h10}, 1'b0, r);
    chk("wrap_g0", 64'(r), 64'b001);
    chk("wrap_wdata", 64'(wdata), 64'h10);

    // stall: previous write still lands, then nothing, ptr held
    step(3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0}, 1'b1, r);
    chk("stall_prev_wr", 64'(wr), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step(3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0}, 1'b1, r);
      chk("stall_ready", 64'(r), 64'd0);
      chk("stall_wr", 64'(wr), 64'd0);
    end
    step(3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0}, 1'b0, r);
    chk("stall_release", 64'(r), 64'b010);
    chk("stall_wdata", 64'(wdata), 64'h44);

    // same address: winner first, loser next
    do_reset();
    step(3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h22, 32'h11}, 1'b0, r);
    chk("same_first", 64'(wdata), 64'h11);
    step(3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h22, 32'h11}, 1'b0, r);
    chk("same_second", 64'(wdata), 64'h22);

    // reset drops a pending write
    step(3'b100, {5'd8, 5'd0, 5'd0}, {32'h88, 32'h0, 32'h0}, 1'b0, r);
    chk("pre_rst_wr", 64'(wr), 64'd1);
    do_reset();

`ifdef RF_ARB_X0_FILTER_EN
    step(3'b011, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h77, 32'h33}, 1'b0, r);
    chk("x0_filtered", 64'(r), 64'b010);
    chk("x0_no_wr", 64'(wr), 64'd0);
    step(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h77, 32'h33}, 1'b0, r);
    chk("x0_then_r0", 64'(r), 64'b001);
    chk("x0_waddr", 64'(waddr), 64'd3);
`else
    step(3'b010, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h77, 32'h33}, 1'b0, r);
    chk("x0_normal_wr", 64'(wr), 64'd1);
    chk("x0_normal_waddr", 64'(waddr), 64'd0);
`endif

    // random traffic; requesters hold a request until it is taken
    do_reset();
    pv = '0; pa = '0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          pv[i] = 1'($urandom_range(0, 1));
          pa[i*AW +: AW] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
          pd[i*DW +: DW] = $urandom;
        end
      end
      step(pv, pa, pd, ($urandom_range(0, 7) == 0), r);
      pv = pv & ~r;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
